// File: rtl/sdram_arbiter2.sv
// Two-master Avalon-MM arbiter in front of a single SDRAM controller slave.
// Read ownership is tracked in a tag FIFO so that each readdatavalid beat returns to the master that issued it.
module sdram_arbiter2 #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int BE_W       = 2,
    parameter int MAX_PEND   = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable_n,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_read_n,
    input  logic              m0_write_n,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable_n,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_read_n,
    input  logic              m1_write_n,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] sdram_s1_address,
    output logic [BE_W-1:0]   sdram_s1_byteenable_n,
    output logic              sdram_s1_chipselect,
    output logic [DATA_W-1:0] sdram_s1_writedata,
    output logic              sdram_s1_read_n,
    output logic              sdram_s1_write_n,
    input  logic [DATA_W-1:0] sdram_s1_readdata,
    input  logic              sdram_s1_readdatavalid,
    input  logic              sdram_s1_waitrequest,
    output logic              arb_error
);

    localparam int PTR_W = $clog2(MAX_PEND);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_PEND);

    typedef enum logic [1:0] {ST_IDLE, ST_G0, ST_G1} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_rrLast;
    logic              r_arbError;
    logic              r_tags [MAX_PEND];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;

    logic              w_req0, w_req1, w_rd0, w_rd1;
    logic              w_empty, w_pop, w_full, w_head;
    logic              w_readN, w_writeN, w_cs, w_accept, w_push;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;

    // A master driving both strobes low is a write; its read is suppressed.
    assign w_req0  = !m0_read_n | !m0_write_n;
    assign w_req1  = !m1_read_n | !m1_write_n;
    assign w_rd0   = !m0_read_n & m0_write_n;
    assign w_rd1   = !m1_read_n & m1_write_n;

    // A same-cycle return frees a slot, so a read waiting on a full FIFO is released immediately.
    assign w_empty = (r_count == '0);
    assign w_pop   = sdram_s1_readdatavalid & !w_empty;
    assign w_full  = (r_count == FULL_CNT) & !w_pop;
    assign w_head  = r_tags[r_rdPtr];

    always_comb begin
        w_addr   = '0;
        w_be     = '0;
        w_wdata  = '0;
        w_readN  = 1'b1;
        w_writeN = 1'b1;
        case (r_state)
            ST_G0: begin
                w_addr   = m0_address;
                w_be     = m0_byteenable_n;
                w_wdata  = m0_writedata;
                w_writeN = m0_write_n;
                w_readN  = !(w_rd0 & !w_full);
            end
            ST_G1: begin
                w_addr   = m1_address;
                w_be     = m1_byteenable_n;
                w_wdata  = m1_writedata;
                w_writeN = m1_write_n;
                w_readN  = !(w_rd1 & !w_full);
            end
            default: ;
        endcase
    end

    assign w_cs     = !w_readN | !w_writeN;
    assign w_accept = w_cs & !sdram_s1_waitrequest;
    assign w_push   = w_accept & !w_readN;

    assign sdram_s1_address      = w_addr;
    assign sdram_s1_byteenable_n = w_be;
    assign sdram_s1_writedata    = w_wdata;
    assign sdram_s1_read_n       = w_readN;
    assign sdram_s1_write_n      = w_writeN;
    assign sdram_s1_chipselect   = w_cs;

    assign m0_waitrequest   = (r_state != ST_G0) | sdram_s1_waitrequest | (w_rd0 & w_full);
    assign m1_waitrequest   = (r_state != ST_G1) | sdram_s1_waitrequest | (w_rd1 & w_full);
    assign m0_readdata      = sdram_s1_readdata;
    assign m1_readdata      = sdram_s1_readdata;
    assign m0_readdatavalid = w_pop & !w_head;
    assign m1_readdatavalid = w_pop & w_head;
    assign arb_error        = r_arbError;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1)
                    w_nextState = (FIXED_PRIO == 0 && !r_rrLast) ? ST_G1 : ST_G0;
                else if (w_req0)
                    w_nextState = ST_G0;
                else if (w_req1)
                    w_nextState = ST_G1;
            end
            ST_G0: begin
                if (w_accept) begin
                    if (w_req1)
                        w_nextState = (FIXED_PRIO != 0 && w_req0) ? ST_G0 : ST_G1;
                    else if (!w_req0)
                        w_nextState = ST_IDLE;
                end else if (!w_req0) begin
                    w_nextState = w_req1 ? ST_G1 : ST_IDLE;
                end
            end
            ST_G1: begin
                if (w_accept) begin
                    if (w_req0)
                        w_nextState = ST_G0;
                    else if (!w_req1)
                        w_nextState = ST_IDLE;
                end else if (!w_req1) begin
                    w_nextState = w_req0 ? ST_G0 : ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= ST_IDLE;
            r_rrLast   <= 1'b0;
            r_arbError <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept)
                r_rrLast <= (r_state == ST_G1);
            if (sdram_s1_readdatavalid && w_empty)
                r_arbError <= 1'b1;
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk_clk) begin
        if (w_push)
            r_tags[r_wrPtr] <= (r_state == ST_G1);
    end

endmodule

// File: tb/tb_sdram_arbiter2.sv
// Randomised and directed bench for sdram_arbiter2 against a queue-based behavioural model.
module tb_sdram_arbiter2;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int MP = 8;
    localparam int FP = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN;
    logic [AW-1:0] mAddr [2];
    logic [BW-1:0] mBe [2];
    logic [DW-1:0] mWd [2];
    logic          mRn [2];
    logic          mWn [2];
    logic [DW-1:0] m0Rd, m1Rd;
    logic          m0Rdv, m1Rdv, m0Wait, m1Wait;
    logic [AW-1:0] sAddr;
    logic [BW-1:0] sBe;
    logic [DW-1:0] sWd;
    logic          sCs, sRn, sWn;
    logic [DW-1:0] sRdata;
    logic          sRdv, sWait;
    logic          arbErr;

    sdram_arbiter2 #(
        .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_PEND(MP), .FIXED_PRIO(FP)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rstN),
        .m0_address(mAddr[0]), .m0_byteenable_n(mBe[0]), .m0_writedata(mWd[0]),
        .m0_read_n(mRn[0]), .m0_write_n(mWn[0]), .m0_readdata(m0Rd),
        .m0_readdatavalid(m0Rdv), .m0_waitrequest(m0Wait),
        .m1_address(mAddr[1]), .m1_byteenable_n(mBe[1]), .m1_writedata(mWd[1]),
        .m1_read_n(mRn[1]), .m1_write_n(mWn[1]), .m1_readdata(m1Rd),
        .m1_readdatavalid(m1Rdv), .m1_waitrequest(m1Wait),
        .sdram_s1_address(sAddr), .sdram_s1_byteenable_n(sBe), .sdram_s1_chipselect(sCs),
        .sdram_s1_writedata(sWd), .sdram_s1_read_n(sRn), .sdram_s1_write_n(sWn),
        .sdram_s1_readdata(sRdata), .sdram_s1_readdatavalid(sRdv),
        .sdram_s1_waitrequest(sWait), .arb_error(arbErr)
    );

    // Model: current owner (-1 none), round-robin memory, queue of read owners in issue order.
    int  mG;
    bit  mRr;
    int  mQ [$];
    bit  mErr;
    int  nG;
    bit  nRr, nAcc, nPush, nPop, nErr;
    int  nPushId;

    int  checks = 0;
    int  errors = 0;

    bit  randomMode;
    bit  busy [2];
    int  dirKind [2];
    int  dirLeft [2];
    int  dirIdx [2];
    logic [AW-1:0] dirBase [2];

    int  rdvOwner [$];
    logic [DW-1:0] rdvData [$];
    int  wrOwner [$];
    int  accWr;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int m, input int kind, input logic [AW-1:0] addr);
        mAddr[m] = addr;
        mBe[m]   = BW'($urandom);
        mWd[m]   = DW'($urandom);
        mRn[m]   = !(kind == 0 || kind == 2 || kind == 3);
        mWn[m]   = !(kind == 1 || kind == 2);
        busy[m]  = 1'b1;
    endtask

    // Masters hold a command until it is accepted; new commands come from the random or directed source.
    task automatic applyStimulus();
        for (int m = 0; m < 2; m++) begin
            if (!busy[m]) begin
                mRn[m] = 1'b1;
                mWn[m] = 1'b1;
                if (randomMode) begin
                    if ($urandom_range(0, 1) == 1)
                        issue(m, int'($urandom_range(0, 3)), AW'($urandom));
                end else if (dirLeft[m] > 0) begin
                    issue(m, dirKind[m], dirBase[m] + AW'(dirIdx[m] * 32));
                    dirIdx[m]++;
                    dirLeft[m]--;
                end
            end
        end
        if (randomMode) begin
            sWait  = ($urandom_range(0, 3) == 0);
            sRdv   = (mQ.size() > 0) && ($urandom_range(0, 2) == 0);
            sRdata = DW'($urandom);
        end
    endtask

    task automatic checkOutput();
        int g;
        int o;
        bit isWr, isRd, full, readOk, cs, expV;
        bit r [2];
        logic [AW-1:0] eA;
        logic [BW-1:0] eBe;
        logic [DW-1:0] eWd;
        g = mG; isWr = 0; isRd = 0; eA = '0; eBe = '0; eWd = '0;
        if (g >= 0) begin
            eA = mAddr[g]; eBe = mBe[g]; eWd = mWd[g];
            isWr = !mWn[g];
            isRd = !mRn[g] && mWn[g];
        end
        full   = (mQ.size() == MP) && !sRdv;
        readOk = isRd && !full;
        cs     = readOk || isWr;
        cmp("s1_address", sAddr, eA);
        cmp("s1_byteenable_n", sBe, eBe);
        cmp("s1_writedata", sWd, eWd);
        cmp("s1_read_n", sRn, !readOk);
        cmp("s1_write_n", sWn, !isWr);
        cmp("s1_chipselect", sCs, cs);
        cmp("m0_waitrequest", m0Wait, (g != 0) || sWait || (isRd && full));
        cmp("m1_waitrequest", m1Wait, (g != 1) || sWait || (isRd && full));
        expV = sRdv && mQ.size() > 0 && mQ[0] == 0;
        cmp("m0_readdatavalid", m0Rdv, expV);
        expV = sRdv && mQ.size() > 0 && mQ[0] == 1;
        cmp("m1_readdatavalid", m1Rdv, expV);
        cmp("m0_readdata", m0Rd, sRdata);
        cmp("m1_readdata", m1Rd, sRdata);
        cmp("arb_error", arbErr, mErr);

        if (m0Rdv) begin rdvOwner.push_back(0); rdvData.push_back(m0Rd); end
        if (m1Rdv) begin rdvOwner.push_back(1); rdvData.push_back(m1Rd); end
        if (sCs && !sWait && !sWn) begin accWr++; wrOwner.push_back(int'(sAddr[20])); end

        nAcc = cs && !sWait;
        nPush = nAcc && readOk;
        nPushId = g;
        nPop = sRdv && mQ.size() > 0;
        nErr = sRdv && mQ.size() == 0;
        r[0] = !mRn[0] || !mWn[0];
        r[1] = !mRn[1] || !mWn[1];
        nRr = mRr;
        if (g < 0) begin
            if (r[0] && r[1]) nG = (FP == 0 && !mRr) ? 1 : 0;
            else if (r[0])    nG = 0;
            else if (r[1])    nG = 1;
            else              nG = -1;
        end else begin
            o = 1 - g;
            if (nAcc) begin
                nRr = (g == 1);
                if (r[o])      nG = (FP != 0) ? (r[0] ? 0 : 1) : o;
                else if (r[g]) nG = g;
                else           nG = -1;
            end else if (!r[g]) begin
                nG = r[o] ? o : -1;
            end else begin
                nG = g;
            end
        end
    endtask

    task automatic commitModel();
        int og;
        og = mG;
        if (nPop)  void'(mQ.pop_front());
        if (nPush) mQ.push_back(nPushId);
        if (nErr)  mErr = 1'b1;
        if (nAcc && og >= 0) busy[og] = 1'b0;
        mG  = nG;
        mRr = nRr;
    endtask

    task automatic half();
        applyStimulus();
        #1;
        checkOutput();
    endtask

    task automatic finishCycle();
        @(posedge clk);
        commitModel();
        @(negedge clk);
    endtask

    task automatic tick();
        half();
        finishCycle();
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        randomMode = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mRn[m] = 1'b1; mWn[m] = 1'b1; mAddr[m] = '0; mBe[m] = '0; mWd[m] = '0;
            busy[m] = 1'b0; dirLeft[m] = 0; dirIdx[m] = 0; dirKind[m] = 0; dirBase[m] = '0;
        end
        sWait = 1'b0; sRdv = 1'b0; sRdata = '0;
        mG = -1; mRr = 1'b0; mErr = 1'b0; mQ.delete();
        rdvOwner.delete(); rdvData.delete(); wrOwner.delete(); accWr = 0;
        @(negedge clk);
        #1;
        cmp("reset m0_waitrequest", m0Wait, 1);
        cmp("reset m1_waitrequest", m1Wait, 1);
        cmp("reset m0_readdatavalid", m0Rdv, 0);
        cmp("reset m1_readdatavalid", m1Rdv, 0);
        cmp("reset arb_error", arbErr, 0);
        cmp("reset chipselect", sCs, 0);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] retData [3];
        int expOwn [3];
        retData[0] = 16'h1111; retData[1] = 16'h2222; retData[2] = 16'h3333;
        expOwn[0] = 0; expOwn[1] = 1; expOwn[2] = 0;

        // Single read with a 3-cycle return.
        resetDut();
        dirKind[0] = 0; dirBase[0] = 24'h000010; dirLeft[0] = 1;
        half();
        cmp("t1 no grant yet", m0Wait, 1);
        finishCycle();
        half();
        cmp("t1 address", sAddr, 24'h000010);
        cmp("t1 read_n", sRn, 0);
        cmp("t1 m0 granted", m0Wait, 0);
        finishCycle();
        tick();
        tick();
        sRdv = 1'b1; sRdata = 16'hBEEF;
        half();
        cmp("t1 m0 valid", m0Rdv, 1);
        cmp("t1 m0 data", m0Rd, 16'hBEEF);
        cmp("t1 m1 valid", m1Rdv, 0);
        finishCycle();
        sRdv = 1'b0;

        // Round-robin contention on writes.
        resetDut();
        dirKind[0] = 1; dirBase[0] = 24'h000000; dirLeft[0] = 4;
        dirKind[1] = 1; dirBase[1] = 24'h100000; dirLeft[1] = 4;
        repeat (12) tick();
        cmp("t2 write count", accWr, 8);
        for (int i = 0; i < 8; i++)
            cmp("t2 order", (i < wrOwner.size()) ? wrOwner[i] : 99, (i % 2 == 0) ? 1 : 0);

        // Interleaved reads return in issue order.
        resetDut();
        dirKind[0] = 0; dirBase[0] = 24'h000A00; dirLeft[0] = 2;
        dirKind[1] = 0; dirBase[1] = 24'h100B00;
        tick();
        dirLeft[1] = 1;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            sRdv = 1'b1; sRdata = retData[i];
            tick();
            sRdv = 1'b0;
            tick();
        end
        cmp("t3 beats", rdvOwner.size(), 3);
        for (int i = 0; i < 3; i++) begin
            cmp("t3 owner", (i < rdvOwner.size()) ? rdvOwner[i] : 99, expOwn[i]);
            cmp("t3 data", (i < rdvData.size()) ? rdvData[i] : 16'h0, retData[i]);
        end

        // Tag FIFO full: 9th read waits, a write still goes, a return releases it.
        resetDut();
        dirKind[1] = 0; dirBase[1] = 24'h100000; dirLeft[1] = 9;
        for (int k = 0; k < 14; k++) begin
            if (k == 8) begin dirKind[0] = 1; dirBase[0] = 24'h000300; dirLeft[0] = 1; end
            if (k == 11) begin sRdv = 1'b1; sRdata = 16'h4444; end
            half();
            if (k == 10) begin
                cmp("t4 full m1 wait", m1Wait, 1);
                cmp("t4 full read_n", sRn, 1);
            end
            if (k == 11) begin
                cmp("t4 release m1 wait", m1Wait, 0);
                cmp("t4 release read_n", sRn, 0);
                cmp("t4 release m1 valid", m1Rdv, 1);
            end
            finishCycle();
            sRdv = 1'b0;
        end
        cmp("t4 m0 write done", accWr, 1);

        // Controller stall holds the command and the grant.
        resetDut();
        dirKind[0] = 1; dirBase[0] = 24'h000555; dirLeft[0] = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin dirKind[1] = 1; dirBase[1] = 24'h100777; dirLeft[1] = 1; end
            sWait = (k >= 1 && k <= 5);
            half();
            if (k >= 1 && k <= 5) begin
                cmp("t5 stall address", sAddr, 24'h000555);
                cmp("t5 stall m0 wait", m0Wait, 1);
                cmp("t5 stall m1 wait", m1Wait, 1);
            end
            finishCycle();
        end
        sWait = 1'b0;
        cmp("t5 writes", accWr, 2);
        cmp("t5 first owner", (wrOwner.size() > 0) ? wrOwner[0] : 99, 0);

        // Reset with reads pending, then a stray beat.
        resetDut();
        dirKind[0] = 0; dirBase[0] = 24'h000700; dirLeft[0] = 3;
        repeat (6) tick();
        resetDut();
        sRdv = 1'b1; sRdata = 16'hDEAD;
        half();
        cmp("t6 m0 valid dropped", m0Rdv, 0);
        cmp("t6 m1 valid dropped", m1Rdv, 0);
        finishCycle();
        sRdv = 1'b0;
        half();
        cmp("t6 arb_error set", arbErr, 1);
        finishCycle();
        repeat (5) tick();
        half();
        cmp("t6 arb_error sticky", arbErr, 1);
        finishCycle();

        // Random traffic.
        resetDut();
        randomMode = 1'b1;
        repeat (3000) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
